cpack_stage12_multilane: RTL

Parametrised successor to the two-word stage-1/stage-2 compressor front end. Each beat carries LANES 32-bit words. The block does the following for every word:
- classifies it against a FIFO-replaced dictionary into a C-Pack pattern;
- emits a code, length and index for it;
- accumulates bit lengths into packer control (shift amount, store count);
- raises a send-back decision per cache line.

It sits between the cache-line fetch and the bit packer.

---
 rtl/cpack_pkg.sv | 42 ++++
 rtl/cpack_stage12_multilane_if.sv | 42 ++++
 rtl/cpack_dict.sv | 85 ++++++++
 rtl/cpack_stage12_multilane.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpack_pkg.sv
// Shared C-Pack definitions: pattern codes, lengths and word width.
// Used by the dictionary, the stage pipeline and its interface.
package cpack_pkg;

    localparam int LEN_W  = 7;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ZZZZ = 3'b000,
        MMMM = 3'b001,
        ZZZX = 3'b010,
        MMMX = 3'b011,
        MMXX = 3'b100,
        XXXX = 3'b101
    } code_e;

    function automatic int len_mmmm(input int idx);
        return 2 + idx;
    endfunction

    function automatic int len_mmmx(input int idx);
        return 12 + idx;
    endfunction

    function automatic int len_mmxx(input int idx);
        return 20 + idx;
    endfunction

    function automatic logic [LEN_W-1:0] len_of(input code_e c, input int idx);
        int n;
        case (c)
            ZZZZ:    n = 2;
            ZZZX:    n = 12;
            MMMM:    n = len_mmmm(idx);
            MMMX:    n = len_mmmx(idx);
            MMXX:    n = len_mmxx(idx);
            default: n = 34;
        endcase
        return LEN_W'(n);
    endfunction

endpackage

// File: rtl/cpack_stage12_multilane_if.sv
// Beat-in / result-out bundle between line fetch, compressor and packer.
// master drives beats and reads results; slave is the compressor.
interface cpack_stage12_multilane_if
    import cpack_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DICT_ENTRY = 16,
    parameter int OUT_WIDTH  = 64
);
    localparam int IDX  = $clog2(DICT_ENTRY);
    localparam int BL_W = $clog2(LANES*34+1);
    localparam int SW   = $clog2(OUT_WIDTH);
    localparam int SCW  = $clog2(LANES*34/OUT_WIDTH+2);

    logic                      i_valid;
    logic [LANES*WORD_W-1:0]   i_word;
    logic                      o_valid;
    logic [LANES*3-1:0]        o_code;
    logic [LANES*LEN_W-1:0]    o_length;
    logic [LANES*IDX-1:0]      o_index;
    logic [BL_W-1:0]           o_beat_len;
    logic [SW-1:0]             o_shift_amount;
    logic [SCW-1:0]            o_store_count;
    logic                      o_store_flag;
    logic                      o_line_end;
    logic                      o_send_back;

    modport master (
        output i_valid, i_word,
        input  o_valid, o_code, o_length, o_index, o_beat_len,
        input  o_shift_amount, o_store_count, o_store_flag,
        input  o_line_end, o_send_back
    );

    modport slave (
        input  i_valid, i_word,
        output o_valid, o_code, o_length, o_index, o_beat_len,
        output o_shift_amount, o_store_count, o_store_flag,
        output o_line_end, o_send_back
    );

endinterface

// File: rtl/cpack_dict.sv
// FIFO-replaced C-Pack dictionary with per-lane lookup.
// All lanes look up the same snapshot; pushes of a beat commit together.
module cpack_dict
    import cpack_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DICT_ENTRY = 16,
    parameter int IDX        = $clog2(DICT_ENTRY)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*WORD_W-1:0]     word,
    input  logic [LANES-1:0]            push,
    input  logic                        clear,
    output logic [LANES-1:0]            hit_full,
    output logic [LANES-1:0]            hit3,
    output logic [LANES-1:0]            hit2,
    output logic [LANES-1:0][IDX-1:0]   idx_full,
    output logic [LANES-1:0][IDX-1:0]   idx3,
    output logic [LANES-1:0][IDX-1:0]   idx2
);

    logic [DICT_ENTRY-1:0][WORD_W-1:0] entry;
    logic [DICT_ENTRY-1:0]             vld;
    logic [IDX-1:0]                    wr_ptr;
    logic [IDX-1:0]                    ptr_next;
    logic [LANES-1:0][IDX-1:0]         wa;

    // Pushing lanes take consecutive slots from wr_ptr in lane order.
    always_comb begin
        ptr_next = wr_ptr;
        wa       = '0;
        for (int k = 0; k < LANES; k++) begin
            wa[k]    = ptr_next;
            ptr_next = ptr_next + IDX'(push[k]);
        end
    end

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        hit_full = '0;
        hit3     = '0;
        hit2     = '0;
        idx_full = '0;
        idx3     = '0;
        idx2     = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int e = DICT_ENTRY-1; e >= 0; e--) begin
                if (vld[e] && entry[e] == word[k*WORD_W +: WORD_W]) begin
                    hit_full[k] = 1'b1;
                    idx_full[k] = IDX'(e);
                end
                if (vld[e] && entry[e][WORD_W-1:8] == word[k*WORD_W+8 +: WORD_W-8]) begin
                    hit3[k] = 1'b1;
                    idx3[k] = IDX'(e);
                end
                if (vld[e] && entry[e][WORD_W-1:16] == word[k*WORD_W+16 +: WORD_W-16]) begin
                    hit2[k] = 1'b1;
                    idx2[k] = IDX'(e);
                end
            end
        end
    end

    // Commit pushes, or wipe the dictionary at a line boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry  <= '0;
            vld    <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            vld    <= '0;
            wr_ptr <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (push[k]) begin
                    entry[wa[k]] <= word[k*WORD_W +: WORD_W];
                    vld[wa[k]]   <= 1'b1;
                end
            end
            wr_ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/cpack_stage12_multilane.sv
// Multi-lane C-Pack stage 1/2: classify words, size the beat,
// track packer offset and decide send-back per cache line.
module cpack_stage12_multilane
    import cpack_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DICT_ENTRY = 16,
    parameter int WORD       = 32,
    parameter int CACHE_LINE = 512,
    parameter int OUT_WIDTH  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    cpack_stage12_multilane_if.slave  bus
);

    localparam int IDX   = $clog2(DICT_ENTRY);
    localparam int BEATS = CACHE_LINE / (LANES*WORD);
    localparam int BL_W  = $clog2(LANES*34+1);
    localparam int SW    = $clog2(OUT_WIDTH);
    localparam int SCW   = $clog2(LANES*34/OUT_WIDTH+2);
    localparam int SUMW  = ((SW > BL_W) ? SW : BL_W) + 1;
    localparam int LB_W  = $clog2(BEATS*LANES*34+1);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                        s1_valid;
    logic [LANES*WORD-1:0]       s1_word;
    logic [LANES-1:0]            hf, h3, h2;
    logic [LANES-1:0][IDX-1:0]   xf, x3, x2;
    logic [LANES-1:0][2:0]       code_c;
    logic [LANES-1:0][LEN_W-1:0] len_c;
    logic [LANES-1:0][IDX-1:0]   idx_c;
    logic [LANES-1:0]            push_c;
    logic [LANES-1:0]            push_v;
    logic                        clear_v;
    logic [BL_W-1:0]             beat_len;
    logic [SW-1:0]               acc;
    logic [LB_W-1:0]             line_bits;
    logic [CW-1:0]               cnt;
    logic [SUMW-1:0]             sum;
    logic [SCW-1:0]              store_cnt;
    logic [LB_W-1:0]             line_total;
    logic                        line_end;

    assign sum        = SUMW'(acc) + SUMW'(beat_len);
    assign store_cnt  = SCW'(sum >> SW);
    assign line_total = line_bits + LB_W'(beat_len);
    assign line_end   = (cnt == CW'(BEATS-1));
    assign push_v     = push_c & {LANES{s1_valid}};
    assign clear_v    = s1_valid & line_end;

    cpack_dict #(
        .LANES      (LANES),
        .DICT_ENTRY (DICT_ENTRY),
        .IDX        (IDX)
    ) u_dict (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .word     (s1_word),
        .push     (push_v),
        .clear    (clear_v),
        .hit_full (hf),
        .hit3     (h3),
        .hit2     (h2),
        .idx_full (xf),
        .idx3     (x3),
        .idx2     (x2)
    );

    // Stage-1 capture of the incoming beat.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) s1_word <= bus.i_word;
        end
    end

    // Per-lane pattern priority, lengths, pushes and beat total.
    always_comb begin
        code_c   = '0;
        len_c    = '0;
        idx_c    = '0;
        push_c   = '0;
        beat_len = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s1_word[k*WORD +: WORD] == '0) begin
                code_c[k] = ZZZZ;
            end else if (s1_word[k*WORD+8 +: WORD-8] == '0) begin
                code_c[k] = ZZZX;
            end else if (hf[k]) begin
                code_c[k] = MMMM;
                idx_c[k]  = xf[k];
            end else if (h3[k]) begin
                code_c[k] = MMMX;
                idx_c[k]  = x3[k];
            end else if (h2[k]) begin
                code_c[k] = MMXX;
                idx_c[k]  = x2[k];
            end else begin
                code_c[k] = XXXX;
            end
            len_c[k]  = len_of(code_e'(code_c[k]), IDX);
            push_c[k] = (code_c[k] == MMMX) || (code_c[k] == MMXX) ||
                        (code_c[k] == XXXX);
            beat_len  = beat_len + BL_W'(len_c[k]);
        end
    end

    // Stage-2 result registers plus line and packer bookkeeping.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bus.o_valid        <= 1'b0;
            bus.o_code         <= '0;
            bus.o_length       <= '0;
            bus.o_index        <= '0;
            bus.o_beat_len     <= '0;
            bus.o_shift_amount <= '0;
            bus.o_store_count  <= '0;
            bus.o_store_flag   <= 1'b0;
            bus.o_line_end     <= 1'b0;
            bus.o_send_back    <= 1'b0;
            acc                <= '0;
            line_bits          <= '0;
            cnt                <= '0;
        end else begin
            bus.o_valid <= s1_valid;
            if (s1_valid) begin
                bus.o_code         <= code_c;
                bus.o_length       <= len_c;
                bus.o_index        <= idx_c;
                bus.o_beat_len     <= beat_len;
                bus.o_shift_amount <= acc;
                bus.o_store_count  <= store_cnt;
                bus.o_store_flag   <= (store_cnt != '0);
                bus.o_line_end     <= line_end;
                bus.o_send_back    <= line_end &&
                                      (line_total >= LB_W'(CACHE_LINE));
                if (line_end) begin
                    acc       <= '0;
                    line_bits <= '0;
                    cnt       <= '0;
                end else begin
                    acc       <= sum[SW-1:0];
                    line_bits <= line_total;
                    cnt       <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
